// File: rtl/ar_scheduler.sv
// rtl/ar_scheduler.sv - round-robin AR issue scheduler with ID busy tracking (optional checks: AR_SCHEDULER_ERR_CHECK_EN)
module ar_scheduler #(
    parameter int NUM_REQ         = 2,
    parameter int MAX_OUTSTANDING = 8,
    parameter int ID_WIDTH        = 4,
    localparam int GW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int OW  = $clog2(MAX_OUTSTANDING + 1),
    localparam int NID = 1 << ID_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ*ID_WIDTH-1:0]  req_arid_i,
    input  logic [NUM_REQ-1:0]           req_arvalid_i,
    output logic [NUM_REQ-1:0]           req_arready_o,
    output logic [ID_WIDTH-1:0]          m_arid_o,
    output logic                         m_arvalid_o,
    input  logic                         m_arready_i,
    input  logic                         r_done_i,
    input  logic [ID_WIDTH-1:0]          r_done_id_i,
    output logic [GW-1:0]                grant_o,
    output logic [OW-1:0]                outstanding_o,
    output logic                         err_o
);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t           state;
    logic [GW-1:0]    rr_ptr;
    logic [NID-1:0]   busy;
    logic [NID-1:0]   busy_next;
    logic             handshake;
    logic             done_hit;
    logic [OW-1:0]    count_eff;
    logic             room;
    logic             pick_valid;
    logic [GW-1:0]    pick_idx;
    logic [ID_WIDTH-1:0] pick_id;

    assign handshake = (state == ISSUE) && m_arready_i;
    // Completions for IDs that are not busy are ignored so the counter cannot underflow.
    assign done_hit  = r_done_i && busy[r_done_id_i];
    // A completion this cycle already frees a slot for the pick taken at this edge.
    assign count_eff = outstanding_o - (done_hit ? OW'(1) : OW'(0));
    assign room      = (count_eff < OW'(MAX_OUTSTANDING));

    // Round-robin search from rr_ptr for the first requester whose ID is not busy.
    always_comb begin
        int idx;
        idx        = 0;
        pick_valid = 1'b0;
        pick_idx   = '0;
        pick_id    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (!pick_valid && req_arvalid_i[idx] &&
                !busy[req_arid_i[idx*ID_WIDTH +: ID_WIDTH]]) begin
                pick_valid = 1'b1;
                pick_idx   = GW'(idx);
                pick_id    = req_arid_i[idx*ID_WIDTH +: ID_WIDTH];
            end
        end
        if (!room) begin
            pick_valid = 1'b0;
        end
    end

    // Busy mask update: the set and clear can never target the same ID in one cycle.
    always_comb begin
        busy_next = busy;
        if (done_hit) begin
            busy_next[r_done_id_i] = 1'b0;
        end
        if (handshake) begin
            busy_next[m_arid_o] = 1'b1;
        end
    end

    // Ready back to the granted requester only on the AR handshake cycle.
    always_comb begin
        req_arready_o = '0;
        if (handshake) begin
            req_arready_o[grant_o] = 1'b1;
        end
    end

    // Issue FSM with registered AR outputs, busy mask and in-flight counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            m_arvalid_o   <= 1'b0;
            m_arid_o      <= '0;
            grant_o       <= '0;
            rr_ptr        <= '0;
            busy          <= '0;
            outstanding_o <= '0;
        end else begin
            busy <= busy_next;
            case ({handshake, done_hit})
                2'b10:   outstanding_o <= outstanding_o + OW'(1);
                2'b01:   outstanding_o <= outstanding_o - OW'(1);
                default: outstanding_o <= outstanding_o;
            endcase
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        m_arid_o    <= pick_id;
                        grant_o     <= pick_idx;
                        m_arvalid_o <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (m_arready_i) begin
                        m_arvalid_o <= 1'b0;
                        rr_ptr      <= (grant_o == GW'(NUM_REQ - 1)) ? '0 : grant_o + GW'(1);
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AR_SCHEDULER_ERR_CHECK_EN
    // Sticky flag for unmatched completions and a granted request withdrawn mid-issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_o <= 1'b0;
        end else if ((r_done_i && !busy[r_done_id_i]) ||
                     ((state == ISSUE) && !req_arvalid_i[grant_o])) begin
            err_o <= 1'b1;
        end
    end
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_ar_scheduler.sv
// tb/tb_ar_scheduler.sv - scoreboard bench for ar_scheduler (NUM_REQ=2, MAX_OUTSTANDING=2)
module tb_ar_scheduler;

    localparam int NR = 2;
    localparam int MO = 2;
    localparam int IW = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR*IW-1:0]  req_arid_i;
    logic [NR-1:0]     req_arvalid_i;
    logic [NR-1:0]     req_arready_o;
    logic [IW-1:0]     m_arid_o;
    logic              m_arvalid_o;
    logic              m_arready_i;
    logic              r_done_i;
    logic [IW-1:0]     r_done_id_i;
    logic [0:0]        grant_o;
    logic [1:0]        outstanding_o;
    logic              err_o;

    int checks   = 0;
    int failures = 0;
    int hs_count = 0;
    int exp_q[$];
    int exp_err;

    ar_scheduler #(.NUM_REQ(NR), .MAX_OUTSTANDING(MO), .ID_WIDTH(IW)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_arid_i    (req_arid_i),
        .req_arvalid_i (req_arvalid_i),
        .req_arready_o (req_arready_o),
        .m_arid_o      (m_arid_o),
        .m_arvalid_o   (m_arvalid_o),
        .m_arready_i   (m_arready_i),
        .r_done_i      (r_done_i),
        .r_done_id_i   (r_done_id_i),
        .grant_o       (grant_o),
        .outstanding_o (outstanding_o),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input int id, input logic v);
        req_arid_i[r*IW +: IW] = IW'(id);
        req_arvalid_i[r]       = v;
    endtask

    task automatic done(input int id);
        r_done_i    = 1'b1;
        r_done_id_i = IW'(id);
        cyc();
        r_done_i    = 1'b0;
    endtask

    task automatic wait_hs(input int start, input string tag);
        for (int k = 0; k < 20 && hs_count == start; k++) cyc();
        check(tag, hs_count - start, 1);
    endtask

    task automatic issue(input int r, input int id);
        int start;
        start = hs_count;
        exp_q.push_back(r * 256 + id);
        set_req(r, id, 1'b1);
        wait_hs(start, "issue_done");
        set_req(r, id, 1'b0);
    endtask

    // Scoreboard: every AR handshake is matched against the next expected grant/ID.
    always @(negedge clk) begin
        if (!reset && m_arvalid_o && m_arready_i) begin
            int e;
            hs_count++;
            check("queue_nonempty", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("hs_id", m_arid_o, e % 256);
                check("hs_grant", grant_o, e / 256);
                check("hs_arready", req_arready_o, 1 << (e / 256));
            end
        end
    end

    initial begin
        int start;
`ifdef AR_SCHEDULER_ERR_CHECK_EN
        exp_err = 1;
`else
        exp_err = 0;
`endif
        reset = 1'b1; req_arid_i = '0; req_arvalid_i = '0;
        m_arready_i = 1'b1; r_done_i = 1'b0; r_done_id_i = '0;
        cyc(); cyc();
        check("rst_arvalid", m_arvalid_o, 0);
        check("rst_arid", m_arid_o, 0);
        check("rst_arready", req_arready_o, 0);
        check("rst_grant", grant_o, 0);
        check("rst_out", outstanding_o, 0);
        check("rst_err", err_o, 0);
        reset = 1'b0;
        cyc();

        // Single request: one-cycle latency to m_arvalid_o.
        exp_q.push_back(0 * 256 + 3);
        start = hs_count;
        set_req(0, 3, 1'b1);
        cyc();
        check("single_latency", m_arvalid_o, 1);
        check("single_id", m_arid_o, 3);
        wait_hs(start, "single_done");
        set_req(0, 3, 1'b0);
        check("single_out", outstanding_o, 1);
        done(3);
        check("single_free", outstanding_o, 0);

        // Round-robin: rr pointer sits at 1, so requester 1 goes first.
        exp_q.push_back(1 * 256 + 2);
        exp_q.push_back(0 * 256 + 1);
        set_req(0, 1, 1'b1);
        set_req(1, 2, 1'b1);
        for (int k = 0; k < 8; k++) cyc();
        check("rr_drained", exp_q.size(), 0);
        check("rr_out", outstanding_o, 2);
        exp_q.push_back(0 * 256 + 1);
        done(1);
        for (int k = 0; k < 6; k++) cyc();
        check("rr_reissue", exp_q.size(), 0);
        check("rr_out2", outstanding_o, 2);
        set_req(0, 1, 1'b0);
        set_req(1, 2, 1'b0);
        done(1);
        done(2);
        check("rr_free", outstanding_o, 0);

        // ID blocking: busy ID 5 is skipped while ID 6 proceeds.
        issue(0, 5);
        exp_q.push_back(1 * 256 + 6);
        start = hs_count;
        set_req(0, 5, 1'b1);
        set_req(1, 6, 1'b1);
        wait_hs(start, "blk_id6");
        set_req(1, 6, 1'b0);
        done(6);
        for (int k = 0; k < 4; k++) cyc();
        check("blk_stall", m_arvalid_o, 0);
        check("blk_out", outstanding_o, 1);
        exp_q.push_back(0 * 256 + 5);
        start = hs_count;
        done(5);
        wait_hs(start, "blk_id5");
        set_req(0, 5, 1'b0);
        done(5);
        check("blk_free", outstanding_o, 0);

        // Full: two in flight blocks a third until a completion.
        issue(0, 0);
        issue(1, 1);
        set_req(0, 2, 1'b1);
        for (int k = 0; k < 5; k++) cyc();
        check("full_block", m_arvalid_o, 0);
        check("full_out", outstanding_o, 2);
        exp_q.push_back(0 * 256 + 2);
        r_done_i = 1'b1; r_done_id_i = 4'd0;
        cyc();
        r_done_i = 1'b0;
        check("full_release", m_arvalid_o, 1);
        cyc();
        set_req(0, 2, 1'b0);
        check("full_out2", outstanding_o, 2);
        done(1);
        done(2);
        check("full_free", outstanding_o, 0);

        // Simultaneous handshake of ID 7 and completion of ID 4.
        issue(0, 4);
        m_arready_i = 1'b0;
        exp_q.push_back(1 * 256 + 7);
        set_req(1, 7, 1'b1);
        for (int k = 0; k < 3; k++) cyc();
        check("stall_valid", m_arvalid_o, 1);
        check("stall_id", m_arid_o, 7);
        check("stall_grant", grant_o, 1);
        check("stall_arready", req_arready_o, 0);
        m_arready_i = 1'b1;
        r_done_i = 1'b1; r_done_id_i = 4'd4;
        cyc();
        r_done_i = 1'b0;
        set_req(1, 7, 1'b0);
        check("simul_out", outstanding_o, 1);
        set_req(0, 7, 1'b1);
        for (int k = 0; k < 4; k++) cyc();
        check("simul_busy7", m_arvalid_o, 0);
        issue(0, 4);
        check("simul_free4", outstanding_o, 2);
        done(4);
        done(7);
        check("simul_done", outstanding_o, 0);

        // Unmatched completion.
        done(9);
        check("err_unmatched", err_o, exp_err);
        check("err_out", outstanding_o, 0);

        // Reset in the middle of an issue.
        issue(0, 8);
        m_arready_i = 1'b0;
        set_req(0, 3, 1'b1);
        cyc(); cyc();
        check("mid_valid", m_arvalid_o, 1);
        reset = 1'b1;
        set_req(0, 3, 1'b0);
        cyc();
        check("mid_rst_valid", m_arvalid_o, 0);
        check("mid_rst_out", outstanding_o, 0);
        check("mid_rst_err", err_o, 0);
        reset = 1'b0;
        m_arready_i = 1'b1;
        cyc(); cyc();
        check("final_queue", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
